wb_flash_cache: RTL
===================

# wb_flash_cache

Read-only, direct-mapped, single-word-per-line cache between the CPU instruction/data Wishbone master and the SPI flash controller (`wb_spimemio`). It turns repeated flash reads into one-cycle hits. It forwards misses downstream as word-aligned Wishbone reads of about 70 cycles each, then fills the line and returns the data. It also provides a global invalidate for use after flash reprogramming or mode changes.

## Interface
Parameters:
- `LINES`, default 16: number of cache lines; power of 2, at least 2. `IDX_W` = log2(`LINES`).
- `ADDR_W`, default 24: byte-address width, the same on both sides.

Ports:
- `wb_clk_i` input 1: single clock for all logic.
- `wb_rst_ni` input 1: asynchronous, active-low reset.
- `wb_adr_i` input `ADDR_W`: upstream byte address; bits [1:0] are ignored.
- `wb_cyc_i` input 1: upstream bus cycle.
- `wb_stb_i` input 1: upstream strobe.
- `wb_dat_o` output 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` output 1: one-cycle acknowledge.
- `m_adr_o` output `ADDR_W`: downstream address, always {adr[`ADDR_W`-1:2], 2'b00}.
- `m_cyc_o` output 1: downstream cycle.
- `m_stb_o` output 1: downstream strobe.
- `m_dat_i` input 32: downstream read data.
- `m_ack_i` input 1: downstream acknowledge, a one-cycle pulse.
- `inv_i` input 1: synchronous global invalidate, sampled every cycle.

## Operation
Address split:
- index = adr[2+:`IDX_W`]
- tag = adr[`ADDR_W`-1:2+`IDX_W`]

Storage per line: 1 valid bit, tag, 32-bit data. Valid bits sit in flops. Tag and data may be flops or a register file with combinational read.

The FSM has three states: IDLE, FILL, RESP.
- IDLE: a request is `wb_cyc_i & wb_stb_i & !wb_ack_o`.
  - Hit (valid[index] and tag match): stay in IDLE. Register `wb_ack_o`=1 and `wb_dat_o`=data[index] for the next cycle.
  - Miss: latch index, tag and the aligned address. Drive `m_cyc_o`=`m_stb_o`=1 and `m_adr_o` from the next cycle. Go to FILL.
- FILL: hold `m_cyc_o`, `m_stb_o` and `m_adr_o` stable until `m_ack_i`.
  - On `m_ack_i`, write data[index]=`m_dat_i` and tag[index]=tag.
  - Set valid[index]=1 unless `inv_i` was seen during this fill, including the ack cycle.
  - Drop `m_cyc_o`/`m_stb_o` in the next cycle and go to RESP.
- RESP: if `wb_cyc_i` is still high, drive `wb_ack_o`=1 with `wb_dat_o` = the filled data for one cycle. Go to IDLE in either case.
- Upstream abort: if `wb_cyc_i` drops during FILL, the fill still completes and is cached, and no upstream ack is issued.
- `inv_i`: clears all valid bits in the same cycle it is sampled, in any state. If it coincides with a hit lookup, the hit is still served from the pre-invalidate contents.
- Data on `wb_dat_o` passes through unmodified. Byte order is the downstream controller's responsibility.
- No writes: requests with any write intent are out of scope, because there is no `wb_we_i` port.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `m_cyc_o`=0, `m_stb_o`=0, `m_adr_o`=0, all valid=0, state=IDLE.
- Hit latency: request sampled at edge N gives `wb_ack_o` high for cycle N+1 only.
- Miss latency:
  - Request at edge N puts `m_stb_o` high from N+1.
  - `m_ack_i` sampled at edge M drops `m_stb_o` and raises `wb_ack_o` in cycle M+1.
  - Total is (M−N)+1 cycles.
- `m_stb_o` is never high in the cycle after the `m_ack_i` edge. The downstream controller must never see a second request from the same strobe.
- Back-to-back: a request held through an ack is not re-accepted in the ack cycle, because of the `!wb_ack_o` gate. The next request is accepted the following cycle.
- At most one outstanding downstream transaction.
- Reset mid-FILL: `m_cyc_o`/`m_stb_o` drop asynchronously and all lines become invalid. A late `m_ack_i` after reset is ignored in IDLE.

## Test plan
- Cold miss: read 0x000104 while the downstream model acks 0xDEADBEEF 70 cycles later. Required: `m_adr_o`=0x000104, exactly one `m_stb_o` transaction, `wb_ack_o` one cycle after `m_ack_i` with `wb_dat_o`=0xDEADBEEF.
- Hit: read 0x000104, then read 0x000106. Required: each acks the cycle after request with 0xDEADBEEF, `m_stb_o` stays 0, and the second has `m_adr_o` unaffected.
- Conflict (`LINES`=16): read 0x000144, which has the same index 1 as 0x000104 and returns 0x12345678, then read 0x000104. Required: both miss, with two downstream reads.
- Invalidate: fill 0x000008, pulse `inv_i` for 1 cycle, reread. Required: a miss is issued. Also pulse `inv_i` mid-fill. Required: that response is delivered, and the following read of the same address misses again.
- Abort: drop `wb_cyc_i` mid-FILL. Required: no `wb_ack_o`, fill completes, and the next read of the same address is a 1-cycle hit.
- Reset: assert `wb_rst_ni`=0 mid-FILL. Required: all outputs go to reset values immediately, and a previously cached address misses after release.

Source files
------------

// File: rtl/wb_flash_cache.sv
// Read-only direct-mapped flash cache: hits ack 1 cycle after request, misses ack 1 cycle after m_ack_i.
// Upstream waits on wb_ack_o; at most one downstream read is outstanding.
module wb_flash_cache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    input  logic [31:0]       m_dat_i,
    input  logic              m_ack_i,
    input  logic              inv_i
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t           state, state_nxt;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag, fill_tag;
    logic             hit, req, serve_hit, start_fill, fill_done;
    logic             inv_seen, aborted;
    logic             unused_adr;

    assign idx        = wb_adr_i[2 +: IDX_W];
    assign tag        = wb_adr_i[ADDR_W-1:2+IDX_W];
    assign hit        = valid[idx] && (tag_mem[idx] == tag);
    assign unused_adr = ^wb_adr_i[1:0];

    always_comb begin
        state_nxt  = state;
        req        = 1'b0;
        serve_hit  = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                req = wb_cyc_i && wb_stb_i && !wb_ack_o;
                if (req && hit) begin
                    serve_hit = 1'b1;
                end else if (req) begin
                    start_fill = 1'b1;
                    state_nxt  = FILL;
                end
            end
            FILL: begin
                if (m_ack_i) begin
                    fill_done = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            m_adr_o  <= '0;
            valid    <= '0;
            fill_idx <= '0;
            fill_tag <= '0;
            inv_seen <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            if (inv_i) begin
                valid <= '0;
            end
            if (serve_hit) begin
                wb_ack_o <= 1'b1;
                wb_dat_o <= data_mem[idx];
            end
            if (start_fill) begin
                m_cyc_o  <= 1'b1;
                m_stb_o  <= 1'b1;
                m_adr_o  <= {wb_adr_i[ADDR_W-1:2], 2'b00};
                fill_idx <= idx;
                fill_tag <= tag;
                inv_seen <= 1'b0;
                aborted  <= 1'b0;
            end
            if (state == FILL) begin
                if (inv_i) inv_seen <= 1'b1;
                if (!wb_cyc_i) aborted <= 1'b1;
            end
            // A fill that raced an invalidate is stored but left invalid.
            if (fill_done) begin
                m_cyc_o         <= 1'b0;
                m_stb_o         <= 1'b0;
                valid[fill_idx] <= !(inv_seen || inv_i);
                if (wb_cyc_i && !aborted) begin
                    wb_ack_o <= 1'b1;
                    wb_dat_o <= m_dat_i;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fill_done) begin
            data_mem[fill_idx] <= m_dat_i;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end
endmodule
